// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared types, constants and sizing helpers for the RMII transmit scheduler
// Contents:
//   state_t                  scheduler FSM states
//   PREAMBLE, SFD            frame lead-in byte values used by the header transmitter
//   ifg_cycles/min_units/max_units  derive clock/unit counts from the stream width n
package ether_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_CRC,
    ST_IFG
  } state_t;

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  // 96 bit times of gap, carried n bits per clock
  function automatic int ifg_cycles(input int n);
    return 96 / n;
  endfunction

  // 46-byte minimum payload in n-bit units
  function automatic int min_units(input int n);
    return (46 * 8) / n;
  endfunction

  // 1500-byte maximum payload in n-bit units
  function automatic int max_units(input int n);
    return (1500 * 8) / n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - pointer-based round-robin arbiter with registered one-hot grant
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req  [NREQ]       request vector
//   load              sample req this cycle (grant and pointer update on a winner)
//   clear             drop the current grant
//   grant [NREQ]      registered one-hot grant
//   win_idx, win_any  combinational winner for the current cycle
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            load,
  input  logic            clear,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   win_idx,
  output logic            win_any
);

  logic [IW-1:0] rr;

  // First set request at or after the pointer, wrapping around.
  always_comb begin : pick
    int s;
    logic [IW-1:0] idx;
    win_any = 1'b0;
    win_idx = '0;
    s       = 0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(rr) + k;
      if (s >= NREQ) s = s - NREQ;
      idx = IW'(s);
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      rr    <= '0;
    end else if (load && win_any) begin
      grant <= NREQ'(1) << win_idx;
      rr    <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);
    end else if (clear) begin
      grant <= '0;
    end
  end

endmodule

// File: rtl/ether_tx_sched.sv
// rtl/ether_tx_sched.sv - frame scheduler: arbitration, header/payload/pad merge, CRC hand-off, IFG
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/dest_mac/etype         per-source frame request and header fields
//   req_axiid/axiiv/last, req_ready  per-source payload stream
//   grant                            one-hot grant of the current frame
//   hdr_start/dest_mac/etype         header transmitter kick-off and latched fields
//   hdr_axiov/axiod/cksum            header transmitter stream
//   axiov/axiod/axio_cksum           merged N-bit output stream
//   crc_go, crc_done                 FCS hand-off to and completion from the CRC block
//   err_underrun, err_oversize       abort pulses
//   busy                             not idle
module ether_tx_sched
  import ether_pkg::*;
#(
  parameter int N          = 2,
  parameter int NREQ       = 2,
  parameter int IFG_CYCLES = ifg_cycles(N),
  parameter int MIN_UNITS  = min_units(N),
  parameter int MAX_UNITS  = max_units(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*48-1:0]   req_dest_mac,
  input  logic [NREQ*16-1:0]   req_etype,
  input  logic [NREQ*N-1:0]    req_axiid,
  input  logic [NREQ-1:0]      req_axiiv,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      req_ready,
  output logic                 hdr_start,
  output logic [47:0]          hdr_dest_mac,
  output logic [15:0]          hdr_etype,
  input  logic                 hdr_axiov,
  input  logic [N-1:0]         hdr_axiod,
  input  logic                 hdr_cksum,
  output logic                 axiov,
  output logic [N-1:0]         axiod,
  output logic                 axio_cksum,
  output logic                 crc_go,
  input  logic                 crc_done,
  output logic                 err_underrun,
  output logic                 err_oversize,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state;
  logic [12:0]   ucnt;
  logic [12:0]   ucnt_nx;
  logic [7:0]    gcnt;
  logic [IW-1:0] gidx;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic          hdr_seen;
  logic          crc_entry;
  logic          g_valid;
  logic          g_last;
  logic [N-1:0]  g_data;
  logic          pay_abort;
  logic          crc_fin;

  assign ucnt_nx   = ucnt + 13'd1;
  assign g_valid   = |(req_axiiv & grant);
  assign g_last    = req_last[gidx];
  assign g_data    = req_axiid[gidx*N +: N];
  assign req_ready = (state == ST_PAYLOAD) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  // Abort conditions and CRC completion are needed both by the FSM and to
  // drop the grant on the same edge that enters IFG.
  assign pay_abort = (state == ST_PAYLOAD) &&
                     (!g_valid || (!g_last && ucnt_nx == 13'(MAX_UNITS)));
  // crc_done is ignored until crc_go has been seen and retired.
  assign crc_fin   = (state == ST_CRC) && crc_done && !crc_go && !crc_entry;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .load    (state == ST_IDLE),
    .clear   (pay_abort || crc_fin),
    .grant   (grant),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ucnt         <= '0;
      gcnt         <= '0;
      gidx         <= '0;
      hdr_seen     <= 1'b0;
      crc_entry    <= 1'b0;
      hdr_start    <= 1'b0;
      hdr_dest_mac <= '0;
      hdr_etype    <= '0;
      axiov        <= 1'b0;
      axiod        <= '0;
      axio_cksum   <= 1'b0;
      crc_go       <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      hdr_start    <= 1'b0;
      crc_go       <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        ST_IDLE: begin
          axiov      <= 1'b0;
          axio_cksum <= 1'b0;
          if (win_any) begin
            gidx         <= win_idx;
            hdr_dest_mac <= req_dest_mac[win_idx*48 +: 48];
            hdr_etype    <= req_etype[win_idx*16 +: 16];
            hdr_start    <= 1'b1;
            hdr_seen     <= 1'b0;
            state        <= ST_HDR;
          end
        end
        ST_HDR: begin
          axiov      <= hdr_axiov;
          axiod      <= hdr_axiod;
          axio_cksum <= hdr_cksum;
          if (hdr_axiov) begin
            hdr_seen <= 1'b1;
          end else if (hdr_seen) begin
            ucnt  <= '0;
            state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_abort) begin
            err_underrun <= !g_valid;
            err_oversize <= g_valid;
            axiov        <= 1'b0;
            axio_cksum   <= 1'b0;
            gcnt         <= 8'(IFG_CYCLES - 1);
            state        <= ST_IFG;
          end else begin
            axiov      <= 1'b1;
            axiod      <= g_data;
            axio_cksum <= 1'b1;
            ucnt       <= ucnt_nx;
            if (g_last) begin
              if (ucnt_nx < 13'(MIN_UNITS)) begin
                state <= ST_PAD;
              end else begin
                crc_entry <= 1'b1;
                state     <= ST_CRC;
              end
            end
          end
        end
        ST_PAD: begin
          axiov      <= 1'b1;
          axiod      <= '0;
          axio_cksum <= 1'b1;
          ucnt       <= ucnt_nx;
          if (ucnt_nx == 13'(MIN_UNITS)) begin
            crc_entry <= 1'b1;
            state     <= ST_CRC;
          end
        end
        ST_CRC: begin
          // crc_go lands in the cycle right after the last unit leaves axiod.
          axiov      <= 1'b0;
          axio_cksum <= 1'b0;
          crc_go     <= crc_entry;
          crc_entry  <= 1'b0;
          if (crc_fin) begin
            gcnt  <= 8'(IFG_CYCLES - 1);
            state <= ST_IFG;
          end
        end
        ST_IFG: begin
          axiov      <= 1'b0;
          axio_cksum <= 1'b0;
          if (gcnt == 8'd0) state <= ST_IDLE;
          else              gcnt  <= gcnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
